// File: rtl/ip_acc.sv
// ip_acc: streaming inner-product accumulator.
// Each accepted beat multiplies SIZE lanes of x by w. The lane products are
// registered (stage 1). They are then summed and added to a saturating
// accumulator (stage 2). A result is presented with a valid/ready handshake
// two cycles after the last beat of a vector.
module ip_acc #(
    parameter int BITWIDTH       = 16,
    parameter int INPUT_BITWIDTH = 8,
    parameter int SIZE           = 8,
    parameter int ACC_BITWIDTH   = 32,
    parameter int MAX_BEATS      = 16,
    parameter int SIGNED         = 1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic                                   in_last,
    input  logic [INPUT_BITWIDTH*SIZE-1:0]         x,
    input  logic [BITWIDTH*SIZE-1:0]               w,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [ACC_BITWIDTH-1:0]                out_sum,
    output logic [$clog2(MAX_BEATS+1)-1:0]         out_beats,
    output logic                                   out_overflow,
    output logic                                   out_len_err
);

    localparam int PW = BITWIDTH + INPUT_BITWIDTH;
    localparam int CW = $clog2(MAX_BEATS + 1);
    // The beat sum can exceed ACC_BITWIDTH. Stage 2 therefore works in a width
    // that holds accumulator plus beat sum exactly. It clamps only at the end.
    localparam int SW = PW + $clog2(SIZE) + 1;
    localparam int WB = (ACC_BITWIDTH > SW) ? ACC_BITWIDTH : SW;
    localparam int W  = WB + 2;

    localparam logic [W-1:0] SMAX = (W'(1) << (ACC_BITWIDTH - 1)) - W'(1);
    localparam logic [W-1:0] SMIN = ~SMAX;
    localparam logic [W-1:0] UMAX = (W'(1) << ACC_BITWIDTH) - W'(1);

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_WAIT, S_DONE} state_t;

    state_t                   state_q;
    logic                     in_ready_q;
    logic                     out_valid_q;
    logic [CW-1:0]            cnt_q;
    logic                     len_err_q;

    logic [SIZE-1:0][PW-1:0]  prod_d;
    logic [SIZE-1:0][PW-1:0]  prod_q;
    logic                     p_valid_q;
    logic                     p_first_q;

    logic [ACC_BITWIDTH-1:0]  acc_d;
    logic [ACC_BITWIDTH-1:0]  acc_q;
    logic                     clamp;
    logic                     ovf_q;

    logic                     accept;
    logic                     first_beat;
    logic [CW-1:0]            cnt_inc;
    logic                     hit_max;

    assign accept     = in_valid & in_ready_q;
    assign first_beat = (state_q == S_IDLE);
    assign cnt_inc    = first_beat ? CW'(1) : cnt_q + CW'(1);
    assign hit_max    = (cnt_inc == CW'(MAX_BEATS));

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign out_sum      = acc_q;
    assign out_beats    = cnt_q;
    assign out_overflow = ovf_q;
    assign out_len_err  = len_err_q;

    // Control FSM: beat counting, length error and registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
            len_err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_ACC: begin
                    if (accept) begin
                        cnt_q     <= cnt_inc;
                        len_err_q <= ~in_last & hit_max;
                        if (in_last || hit_max) begin
                            state_q    <= S_WAIT;
                            in_ready_q <= 1'b0;
                        end else begin
                            state_q <= S_ACC;
                        end
                    end
                end
                S_WAIT: begin
                    state_q     <= S_DONE;
                    out_valid_q <= 1'b1;
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Stage 1 lane products, sign- or zero-extended to full product width.
    always_comb begin
        logic [PW+1:0] xe;
        logic [PW+1:0] we;
        logic [PW+1:0] pf;
        prod_d = '0;
        xe     = '0;
        we     = '0;
        pf     = '0;
        for (int unsigned i = 0; i < SIZE; i++) begin
            if (SIGNED != 0) begin
                xe = (PW+2)'($signed(x[INPUT_BITWIDTH*i +: INPUT_BITWIDTH]));
                we = (PW+2)'($signed(w[BITWIDTH*i +: BITWIDTH]));
            end else begin
                xe = (PW+2)'(x[INPUT_BITWIDTH*i +: INPUT_BITWIDTH]);
                we = (PW+2)'(w[BITWIDTH*i +: BITWIDTH]);
            end
            pf        = xe * we;
            prod_d[i] = pf[PW-1:0];
        end
    end

    // Stage 1 register: capture products of an accepted beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_q    <= '0;
            p_valid_q <= 1'b0;
            p_first_q <= 1'b0;
        end else begin
            p_valid_q <= accept;
            p_first_q <= accept & first_beat;
            if (accept) begin
                prod_q <= prod_d;
            end
        end
    end

    // Stage 2 beat sum plus accumulator, clamped to the accumulator range.
    always_comb begin
        logic [W-1:0] beat_sum;
        logic [W-1:0] base;
        logic [W-1:0] tot;
        beat_sum = '0;
        for (int unsigned i = 0; i < SIZE; i++) begin
            if (SIGNED != 0) begin
                beat_sum = beat_sum + W'($signed(prod_q[i]));
            end else begin
                beat_sum = beat_sum + W'(prod_q[i]);
            end
        end
        if (p_first_q) begin
            base = '0;
        end else if (SIGNED != 0) begin
            base = W'($signed(acc_q));
        end else begin
            base = W'(acc_q);
        end
        tot   = base + beat_sum;
        acc_d = tot[ACC_BITWIDTH-1:0];
        clamp = 1'b0;
        if (SIGNED != 0) begin
            if ($signed(tot) > $signed(SMAX)) begin
                acc_d = SMAX[ACC_BITWIDTH-1:0];
                clamp = 1'b1;
            end else if ($signed(tot) < $signed(SMIN)) begin
                acc_d = SMIN[ACC_BITWIDTH-1:0];
                clamp = 1'b1;
            end
        end else if (tot > UMAX) begin
            acc_d = UMAX[ACC_BITWIDTH-1:0];
            clamp = 1'b1;
        end
    end

    // Stage 2 register: accumulator and sticky overflow, restarted on first beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else if (p_valid_q) begin
            acc_q <= acc_d;
            ovf_q <= p_first_q ? clamp : (ovf_q | clamp);
        end
    end

endmodule

// File: doc/ip_acc.md
IP_ACC -- requirements
Module: ip_acc

Interface
REQ-001 SHALL have parameter BITWIDTH, default 16, weight lane width.
REQ-002 SHALL have parameter INPUT_BITWIDTH, default 8, input lane width.
REQ-003 SHALL have parameter SIZE, default 8, lanes per beat.
REQ-004 SHALL have parameter ACC_BITWIDTH, default 32, accumulator and result width; must be at least BITWIDTH+INPUT_BITWIDTH.
REQ-005 SHALL have parameter MAX_BEATS, default 16, maximum beats per vector.
REQ-006 SHALL have parameter SIGNED, default 1; 1 selects two's-complement operands, 0 selects unsigned.
REQ-007 SHALL have port clk, input, 1, single clock, rising edge.
REQ-008 SHALL have port rst, input, 1, asynchronous, active-high reset.
REQ-009 SHALL have port in_valid, input, 1, a beat is present.
REQ-010 SHALL have port in_ready, output, 1, the block accepts the beat.
REQ-011 SHALL have port in_last, input, 1, final beat of the vector.
REQ-012 SHALL have port x, input, INPUT_BITWIDTH*SIZE, packed lanes, lane i at [INPUT_BITWIDTH*i +: INPUT_BITWIDTH].
REQ-013 SHALL have port w, input, BITWIDTH*SIZE, packed lanes, lane i at [BITWIDTH*i +: BITWIDTH].
REQ-014 SHALL have port out_valid, output, 1, a result is held.
REQ-015 SHALL have port out_ready, input, 1, the consumer accepts the result.
REQ-016 SHALL have port out_sum, output, ACC_BITWIDTH, the inner product of the vector.
REQ-017 SHALL have port out_beats, output, clog2(MAX_BEATS+1), beats in the vector.
REQ-018 SHALL have port out_overflow, output, 1, saturation occurred in the vector.
REQ-019 SHALL have port out_len_err, output, 1, the vector was terminated at MAX_BEATS without in_last.

Function
REQ-020 A beat SHALL be accepted in any cycle where in_valid and in_ready are both high; accepted inputs are sampled at that rising edge.
REQ-021 States SHALL be IDLE, ACC, WAIT and DONE; in_ready SHALL be 1 in IDLE and ACC, and 0 in WAIT and DONE.
REQ-022 Transitions SHALL be:
- IDLE to ACC on an accepted beat with in_last=0.
- IDLE or ACC to WAIT on an accepted beat with in_last=1.
- ACC to WAIT on the accepted beat that brings the count to MAX_BEATS.
- WAIT to DONE unconditionally after one cycle.
- DONE to IDLE when out_valid and out_ready are both high.
REQ-023 Stage 1 SHALL register SIZE lane products of width BITWIDTH+INPUT_BITWIDTH, sign-extended when SIGNED=1 and zero-extended when SIGNED=0.
REQ-024 Stage 2 SHALL sum the registered products, extended to ACC_BITWIDTH, and add the sum to the accumulator, one cycle after stage 1.
REQ-025 On the first beat of a vector, the accumulator SHALL load the beat sum instead of adding it to the prior value.
REQ-026 Each accumulation SHALL saturate:
- SIGNED=1 range: -2^(ACC_BITWIDTH-1) to 2^(ACC_BITWIDTH-1)-1.
- SIGNED=0 range: 0 to 2^ACC_BITWIDTH-1.
- Any clamp SHALL set a sticky overflow flag, cleared at the start of the next vector.
REQ-027 Latency SHALL be fixed: if the last beat is accepted in cycle T, out_valid SHALL be high from cycle T+2.
REQ-028 While out_valid=1, out_sum, out_beats, out_overflow and out_len_err SHALL be held stable until the handshake.
REQ-029 After the output handshake, out_valid SHALL be 0 and in_ready SHALL be 1 in the next cycle; no beat is accepted in the handshake cycle.
REQ-030 When MAX_BEATS beats are accepted without in_last, out_len_err SHALL be 1; in_last on beat MAX_BEATS SHALL give out_len_err=0.
REQ-031 An in_last beat as the first beat SHALL produce a one-beat result with out_beats=1.
REQ-032 in_valid=0 cycles in the middle of a vector SHALL pause accumulation without changing the result.

Reset
REQ-033 While rst=1, the FSM SHALL go to IDLE, and the pipeline registers, accumulator and counter SHALL clear immediately, independent of clk.
REQ-034 Reset values SHALL be in_ready=1 (after release), out_valid=0, out_sum=0, out_beats=0, out_overflow=0, out_len_err=0.
REQ-035 Reset mid-vector or mid-drain SHALL discard the partial result; the first vector after reset SHALL be unaffected by it.

Verification (SIZE=4, INPUT_BITWIDTH=8, BITWIDTH=16, ACC_BITWIDTH=32, SIGNED=1, MAX_BEATS=4 unless noted)
REQ-036 One beat x={1,2,3,4}, w={5,6,7,8}, in_last=1 at cycle T -> out_sum=70 and out_beats=1 from T+2; in_ready=0 during T+1 and T+2.
REQ-037 Three beats, all lanes x=1 and w=1, with an idle gap after beat 1 -> out_sum=12, out_beats=3, out_overflow=0.
REQ-038 ACC_BITWIDTH=20, one beat with all lanes x=127, w=32767 -> out_sum=524287, out_overflow=1.
REQ-039 ACC_BITWIDTH=20, same beat with x=-128 -> out_sum=-524288, out_overflow=1.
REQ-040 Next vector after a saturated one, x={1,2,3,4}, w={5,6,7,8} -> out_sum=70, out_overflow=0.
REQ-041 out_ready held low 5 cycles with a result pending -> out_valid=1 and all outputs stable, in_ready=0 throughout; on out_ready=1, out_valid=0 and in_ready=1 in the next cycle.
REQ-042 Four beats with in_last=0, x={1,1,1,1}, w={2,2,2,2} -> out_sum=32, out_beats=4, out_len_err=1.
REQ-043 rst pulsed after beat 2 of a vector -> all outputs return to reset values at once; the next one-beat vector from REQ-036 gives out_sum=70.
